// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: pc, imem handshake, decoder output register, branch redirect
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] PC_INC      = 16'd4,
  parameter logic [15:0] NOP_INSTR   = 16'h0F00,
  parameter int          BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        branch_link,
  input  logic [15:0] branch_pc,
  input  logic [15:0] branch_offset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] instruction,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  output logic [15:0] link_addr,
  output logic        link_valid,
  output logic        halted
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_REDIRECT, S_HALT} state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t      state;
  logic [15:0] pc;
  logic [3:0]  boot_cnt;
  logic        can_accept;
  logic        transfer;
  logic        redirect;

  assign can_accept = ~instr_valid | ~stall;
  assign imem_req   = (state == S_RUN) & can_accept & ~branch_taken;
  assign imem_addr  = pc;
  assign transfer   = imem_req & imem_ready;
  // branches arriving while still booting are ignored entirely
  assign redirect   = branch_taken & (state != S_BOOT);
  assign halted     = (state == S_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      boot_cnt    <= 4'd0;
      instruction <= NOP_INSTR;
      instr_pc    <= 16'h0000;
      instr_valid <= 1'b0;
      link_addr   <= 16'h0000;
      link_valid  <= 1'b0;
    end else begin
      link_valid <= 1'b0;
      // flush beats stall: the held instruction is on the wrong path
      if (redirect) begin
        pc          <= branch_pc + branch_offset;
        instruction <= NOP_INSTR;
        instr_valid <= 1'b0;
        if (branch_link) begin
          link_addr  <= branch_pc + PC_INC;
          link_valid <= 1'b1;
        end
      end else if (transfer) begin
        instruction <= imem_data;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + PC_INC;
      end else if (!stall) begin
        instruction <= NOP_INSTR;
        instr_valid <= 1'b0;
      end

      case (state)
        S_BOOT: begin
          boot_cnt <= boot_cnt + 4'd1;
          if (boot_cnt == BOOT_LAST) state <= halt ? S_HALT : S_RUN;
        end
        S_RUN: begin
          if (branch_taken) state <= S_REDIRECT;
          else if (halt)    state <= S_HALT;
        end
        S_REDIRECT: state <= halt ? S_HALT : S_RUN;
        S_HALT: begin
          if (!branch_taken && !halt) state <= S_RUN;
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit
module tb_fetch_unit;

  localparam int          BOOT = 2;
  localparam logic [15:0] NOP  = 16'h0F00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        halt = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic        branch_link = 1'b0;
  logic [15:0] branch_pc = 16'h0000;
  logic [15:0] branch_offset = 16'h0000;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] instruction;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic [15:0] link_addr;
  logic        link_valid;
  logic        halted;

  fetch_unit dut (
    .clk(clk), .reset(reset), .halt(halt), .stall(stall),
    .branch_taken(branch_taken), .branch_link(branch_link),
    .branch_pc(branch_pc), .branch_offset(branch_offset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .link_addr(link_addr), .link_valid(link_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // rising edges seen since reset release
  int n = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) n = 0;
    else        n = n + 1;
  end

  // reference model: program-order fetch address, queue of fetched-but-unconsumed words
  logic [15:0] q_pc[$];
  logic [15:0] q_data[$];
  logic [15:0] model_pc = 16'h0000;
  logic [15:0] exp_link = 16'h0000;
  bit prev_br = 0, prev_halt = 0, prev_halted = 0, link_due = 0;
  bit booted, e_req, e_halted;

  always @(negedge clk) begin
    if (!reset) begin
      q_pc.delete();
      q_data.delete();
      model_pc = 16'h0000;
      prev_br = 0; prev_halt = 0; prev_halted = 0; link_due = 0;
    end else begin
      booted   = (n >= BOOT);
      e_req    = booted && !prev_br && !prev_halt && (q_pc.size() == 0 || !stall) && !branch_taken;
      e_halted = booted && (prev_br ? prev_halted : prev_halt);
      check("imem_req", 16'(imem_req), 16'(e_req));
      if (imem_req) check("imem_addr", imem_addr, model_pc);
      check("halted", 16'(halted), 16'(e_halted));
      check("instr_valid", 16'(instr_valid), 16'(q_pc.size() != 0));
      if (q_pc.size() != 0) begin
        check("instruction", instruction, q_data[0]);
        check("instr_pc", instr_pc, q_pc[0]);
      end else begin
        check("bubble_nop", instruction, NOP);
      end
      check("link_valid", 16'(link_valid), 16'(link_due));
      if (link_due) check("link_addr", link_addr, exp_link);

      if (branch_taken) begin
        if (q_pc.size() != 0) begin
          void'(q_pc.pop_front());
          void'(q_data.pop_front());
        end
        model_pc = branch_pc + branch_offset;
        link_due = branch_link;
        exp_link = branch_pc + 16'd4;
      end else begin
        link_due = 0;
        if (q_pc.size() != 0 && !stall) begin
          void'(q_pc.pop_front());
          void'(q_data.pop_front());
        end
        if (imem_req && imem_ready) begin
          q_pc.push_back(model_pc);
          q_data.push_back(mem_word(model_pc));
          model_pc = model_pc + 16'd4;
        end
      end
      prev_br     = branch_taken;
      prev_halt   = halt;
      prev_halted = e_halted;
    end
  end

  bit last_br = 0;
  bit found;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    imem_ready = 1'b1;
    imem_data = mem_word(imem_addr);
    // clean boot with zero-wait memory
    repeat (20) begin
      @(posedge clk); #1;
      imem_data = mem_word(imem_addr);
    end
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      stall      = ($urandom_range(3) == 0);
      imem_ready = ($urandom_range(9) < 7);
      if ($urandom_range(29) == 0) halt = ~halt;
      branch_taken = 1'b0;
      branch_link  = 1'b0;
      if (n >= BOOT && !last_br) begin
        if (i % 250 == 100) begin
          branch_taken  = 1'b1;
          branch_link   = 1'b1;
          branch_pc     = 16'hFFF0;
          branch_offset = 16'h0008;
        end else if ($urandom_range(15) == 0) begin
          branch_taken  = 1'b1;
          branch_link   = 1'($urandom_range(1));
          branch_pc     = instr_valid ? instr_pc : 16'($urandom);
          branch_offset = 16'($urandom) & 16'hFFFC;
        end
      end
      last_br = branch_taken;
      imem_data = mem_word(imem_addr);
    end
    @(posedge clk); #1;
    halt = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_link = 1'b0;
    imem_ready = 1'b1;
    imem_data = mem_word(imem_addr);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #1;
      imem_data = mem_word(imem_addr);
      if (imem_req) found = 1;
    end
    check("wait_req_before_reset", 16'(found), 16'd1);
    // asynchronous reset in the middle of a request
    #2 reset = 1'b0;
    #1;
    check("rst_imem_req", 16'(imem_req), 16'd0);
    check("rst_imem_addr", imem_addr, 16'h0000);
    check("rst_instruction", instruction, NOP);
    check("rst_instr_pc", instr_pc, 16'h0000);
    check("rst_instr_valid", 16'(instr_valid), 16'd0);
    check("rst_link_addr", link_addr, 16'h0000);
    check("rst_link_valid", 16'(link_valid), 16'd0);
    check("rst_halted", 16'(halted), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the decoder. Owns the program counter, issues single-cycle handshaked reads to instruction memory, and presents one registered 16-bit instruction with its PC to the decoder, which holds it under back-pressure. Accepts the decoder's taken-branch redirect (branch offset, branch-and-link), flushes the wrong-path instruction, and produces the link address for R14.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset
- PC_INC, 4, PC advance per fetched instruction (byte addressing, matches bOffset<<2)
- NOP_INSTR, 16'h0F00, bubble instruction; condition field [11:8]=1111 never executes
- BOOT_CYCLES, 2, idle cycles after reset release before first fetch (range 1..15)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- halt  in  1  level; stop issuing fetches while high
- stall  in  1  downstream cannot accept; hold instruction/instr_pc/instr_valid
- branch_taken  in  1  decoder branch AND conditionBool, one-cycle pulse
- branch_link  in  1  qualifies branch_taken as BL
- branch_pc  in  16  instr_pc of the branch instruction
- branch_offset  in  16  sign-extended byte offset (decoder bOffset)
- imem_req  out  1  read request
- imem_addr  out  16  read address (= pc)
- imem_ready  in  1  transfer completes when imem_req & imem_ready
- imem_data  in  16  read data, valid in the completing cycle
- instruction  out  16  instruction to decoder
- instr_pc  out  16  address of instruction
- instr_valid  out  1  instruction is real (0 = bubble)
- link_addr  out  16  return address for BL
- link_valid  out  1  one-cycle pulse, write link_addr to R14
- halted  out  1  state is HALT

## Operation
- State: pc[15:0], boot counter[3:0], FSM {BOOT, RUN, REDIRECT, HALT}, output register.
- can_accept = ~instr_valid | ~stall. imem_req = (state==RUN) & can_accept & ~branch_taken (combinational). imem_addr = pc always.
- Transfer (imem_req & imem_ready): instruction<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+PC_INC (mod 2^16, 16'hFFFC -> 16'h0000).
- No transfer and ~stall: instr_valid<=0, instruction<=NOP_INSTR. Stall with no transfer: output register holds.
- Dropping imem_req before imem_ready is legal (no transaction occurred).
- FSM:
  - BOOT: count up each cycle; after BOOT_CYCLES cycles -> RUN (-> HALT if halt).
  - RUN: branch_taken -> REDIRECT; else halt -> HALT; else stay.
  - REDIRECT: imem_req=0 for exactly one cycle; -> HALT if halt, else RUN.
  - HALT: imem_req=0, halted=1; halt low -> RUN. branch_taken in HALT still redirects pc/flushes, remains HALT.
- branch_taken (any state except BOOT, where it is ignored): pc<=branch_pc+branch_offset (16-bit wrap); instruction<=NOP_INSTR, instr_valid<=0, regardless of stall (flush beats stall); imem_data in that cycle discarded.
- branch_taken & branch_link: link_addr<=branch_pc+PC_INC, link_valid<=1 next cycle for one cycle; otherwise link_valid<=0, link_addr holds.
- Priority: reset > branch_taken > halt > stall > transfer.

## Timing
- Reset (async, immediate): pc=RESET_PC, state=BOOT, imem_req=0, imem_addr=RESET_PC, instruction=NOP_INSTR, instr_pc=0, instr_valid=0, link_addr=0, link_valid=0, halted=0.
- First imem_req in cycle BOOT_CYCLES after first rising edge with reset high.
- Fetch latency: transfer in cycle N -> instruction/instr_valid visible cycle N+1. Zero-wait memory, no stall: one instruction per cycle.
- Redirect: branch_taken cycle N -> bubble in N+1, REDIRECT in N+1 (no request), first target request N+2, target instruction valid N+3.
- halt asserted cycle N: no request from N+1; in-cycle-N transfer still completes.
- Reset mid-transfer: imem_req drops asynchronously; no data captured.

## Test plan
- Boot: release reset, BOOT_CYCLES=2, imem_ready=1 -> imem_req first high cycle 2, addresses 0,4,8, instr_valid continuous from cycle 3.
- Stall: stall high 3 cycles with instr at pc 8 -> instruction/instr_pc=8 held, imem_req=0, no pc advance; release -> pc 12 fetched next.
- Branch: branch_pc=16'h0010, offset=16'hFFF8, with simultaneous transfer -> data discarded, bubble (NOP_INSTR, valid 0), one request-free cycle, next imem_addr=16'h0008.
- BL: branch_link=1, branch_pc=16'h0040 -> link_valid one cycle, link_addr=16'h0044; branch during stall flushes held instruction.
- Wait states and wrap: imem_ready low 2 cycles at pc=16'hFFFC -> imem_addr stable, then capture, next imem_addr=16'h0000.
- Halt/reset: halt mid-run -> halted=1, imem_req=0, resume same pc; reset low mid-request -> all outputs to reset values without clock.
